// File: rtl/mac_pkg.sv
// Shared definitions for the GMII MAC link sequencer: state encoding and default timing.
package mac_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ARP_REQ  = 4'd1,
    ST_ARP_SEND = 4'd2,
    ST_ARP_WAIT = 4'd3,
    ST_ARP_NAP0 = 4'd4,
    ST_NAP      = 4'd5,
    ST_CHECK    = 4'd6,
    ST_WAIT     = 4'd7,
    ST_SEND     = 4'd8,
    ST_RECV     = 4'd9,
    ST_FAIL     = 4'd10
  } link_state_t;

  localparam int unsigned DEF_BOOT_CYC      = 125_000_000;
  localparam int unsigned DEF_ARP_RETRY_CYC = 125_000_000;
  localparam int unsigned DEF_NAP_CYC       = 90;
  localparam int unsigned DEF_N_TX          = 2;
  localparam int unsigned DEF_ARP_MAX_RETRY = 8;

  // States whose duration is measured by the wait counter.
  function automatic logic is_counting(link_state_t s);
    return (s == ST_IDLE) || (s == ST_ARP_WAIT) || (s == ST_NAP);
  endfunction

endpackage

// File: rtl/mac_link_ctrl_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot winner searched from last+1, plus the last-grant pointer.
module rr_arbiter
  import mac_pkg::*;
#(
  parameter int unsigned N = DEF_N_TX
) (
  input  logic         gmii_tx_clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         load,
  output logic [N-1:0] grant
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] last_reg;
  logic          found;
  int            win;

  always_comb begin
    found = 1'b0;
    win   = 0;
    grant = '0;
    for (int k = 1; k <= int'(N); k++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!found && req[i] && (i == (int'(last_reg) + k) % int'(N))) begin
          found = 1'b1;
          win   = i;
        end
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      grant[i] = found && (i == win);
    end
  end

  // Reset to N-1 so the very first grant goes to client 0.
  always_ff @(posedge gmii_tx_clk or posedge rst) begin
    if (rst) begin
      last_reg <= IW'(N - 1);
    end else if (load) begin
      last_reg <= IW'(win);
    end
  end

endmodule

// File: rtl/mac_link_ctrl.sv
// Link sequencer: boot wait, ARP resolution with retry, then RX-priority / round-robin TX arbitration.
// Optional ARP retry limit enabled by defining MAC_ARP_RETRY_LIMIT_EN.
module mac_link_ctrl
  import mac_pkg::*;
#(
  parameter int unsigned BOOT_CYC      = DEF_BOOT_CYC,
  parameter int unsigned ARP_RETRY_CYC = DEF_ARP_RETRY_CYC,
  parameter int unsigned NAP_CYC       = DEF_NAP_CYC,
  parameter int unsigned N_TX          = DEF_N_TX,
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned ARP_MAX_RETRY = DEF_ARP_MAX_RETRY
) (
  input  logic            gmii_tx_clk,
  input  logic            rst,
  output logic            arp_request_req,
  input  logic            mac_send_end,
  input  logic            arp_found,
  input  logic            mac_not_exist,
  input  logic            almost_full,
  input  logic            udp_rx_dv,
  output logic            fs_udp_rx,
  input  logic            fd_udp_rx,
  input  logic [N_TX-1:0] fs_tx,
  input  logic [N_TX-1:0] fd_tx,
  output logic [N_TX-1:0] tx_grant,
  output logic            link_up,
  output logic            arp_fail,
  output logic [3:0]      state_o
);

  localparam logic [CNT_W-1:0] BOOT_LAST  = CNT_W'(BOOT_CYC - 1);
  localparam logic [CNT_W-1:0] RETRY_LAST = CNT_W'(ARP_RETRY_CYC - 1);
  localparam logic [CNT_W-1:0] NAP_LAST   = CNT_W'(NAP_CYC - 1);

  link_state_t     state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [N_TX-1:0]  grant_reg, grant_next;
  logic [N_TX-1:0]  arb_grant;
  logic             arb_load;
  logic             wait_timeout;
  logic             retry_exhausted;

  assign wait_timeout = (cnt_reg == RETRY_LAST);

  rr_arbiter #(.N(N_TX)) u_arb (
    .gmii_tx_clk (gmii_tx_clk),
    .rst         (rst),
    .req         (fs_tx),
    .load        (arb_load),
    .grant       (arb_grant)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:     if (cnt_reg == BOOT_LAST) state_next = ST_ARP_REQ;
      ST_ARP_REQ:  state_next = ST_ARP_SEND;
      ST_ARP_SEND: if (mac_send_end) state_next = ST_ARP_WAIT;
      ST_ARP_WAIT: begin
        if (arp_found)         state_next = ST_ARP_NAP0;
        else if (wait_timeout) state_next = retry_exhausted ? ST_FAIL : ST_ARP_REQ;
      end
      ST_ARP_NAP0: state_next = ST_NAP;
      ST_NAP:      if (cnt_reg == NAP_LAST) state_next = ST_CHECK;
      ST_CHECK: begin
        if (mac_not_exist)     state_next = ST_ARP_REQ;
        else if (!almost_full) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (udp_rx_dv)  state_next = ST_RECV;
        else if (|fs_tx) state_next = ST_SEND;
      end
      ST_SEND:     if (|(fd_tx & grant_reg)) state_next = ST_NAP;
      ST_RECV:     if (fd_udp_rx) state_next = ST_NAP;
`ifdef MAC_ARP_RETRY_LIMIT_EN
      ST_FAIL:     state_next = ST_FAIL;
`endif
      default:     state_next = ST_IDLE;
    endcase
  end

  // Counter restarts on every state change so each dwell begins at zero.
  always_comb begin
    cnt_next = cnt_reg;
    if (state_next != state_reg)   cnt_next = '0;
    else if (is_counting(state_reg)) cnt_next = cnt_reg + CNT_W'(1);
  end

  assign arb_load = (state_reg == ST_WAIT) && (state_next == ST_SEND);

  always_comb begin
    grant_next = '0;
    if (state_next == ST_SEND) grant_next = (state_reg == ST_SEND) ? grant_reg : arb_grant;
  end

  always_ff @(posedge gmii_tx_clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      grant_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      grant_reg <= grant_next;
    end
  end

`ifdef MAC_ARP_RETRY_LIMIT_EN
  localparam int unsigned RW = $clog2(ARP_MAX_RETRY + 1);
  logic [RW-1:0] retry_reg;

  always_ff @(posedge gmii_tx_clk or posedge rst) begin
    if (rst) begin
      retry_reg <= '0;
    end else if (state_reg == ST_ARP_WAIT) begin
      if (arp_found)         retry_reg <= '0;
      else if (wait_timeout) retry_reg <= retry_reg + RW'(1);
    end
  end

  assign retry_exhausted = (retry_reg == RW'(ARP_MAX_RETRY - 1));
  assign arp_fail        = (state_reg == ST_FAIL);
`else
  assign retry_exhausted = 1'b0;
  assign arp_fail        = 1'b0;
`endif

  assign arp_request_req = (state_reg == ST_ARP_REQ);
  assign fs_udp_rx       = (state_reg == ST_RECV);
  assign link_up         = state_reg inside {ST_NAP, ST_CHECK, ST_WAIT, ST_SEND, ST_RECV};
  assign tx_grant        = grant_reg;
  assign state_o         = state_reg;

endmodule

// File: tb/tb_mac_link_ctrl.sv
// Self-checking bench for mac_link_ctrl: directed scenarios with literal checks, then random traffic vs a reference model.
module tb_mac_link_ctrl;

  localparam int BOOT  = 20;
  localparam int RETRY = 30;
  localparam int NAPC  = 5;
  localparam int N     = 3;
  localparam int MAXR  = 2;

  logic         gmii_tx_clk = 1'b0;
  logic         rst = 1'b1;
  logic         arp_request_req, fs_udp_rx, link_up, arp_fail;
  logic         mac_send_end, arp_found, mac_not_exist, almost_full, udp_rx_dv, fd_udp_rx;
  logic [N-1:0] fs_tx, fd_tx, tx_grant;
  logic [3:0]   state_o;

  always #5 gmii_tx_clk = ~gmii_tx_clk;

  mac_link_ctrl #(
    .BOOT_CYC(BOOT), .ARP_RETRY_CYC(RETRY), .NAP_CYC(NAPC),
    .N_TX(N), .CNT_W(32), .ARP_MAX_RETRY(MAXR)
  ) dut (
    .gmii_tx_clk(gmii_tx_clk), .rst(rst), .arp_request_req(arp_request_req),
    .mac_send_end(mac_send_end), .arp_found(arp_found), .mac_not_exist(mac_not_exist),
    .almost_full(almost_full), .udp_rx_dv(udp_rx_dv), .fs_udp_rx(fs_udp_rx),
    .fd_udp_rx(fd_udp_rx), .fs_tx(fs_tx), .fd_tx(fd_tx), .tx_grant(tx_grant),
    .link_up(link_up), .arp_fail(arp_fail), .state_o(state_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase number, cycles left in a timed phase, granted client index.
  int m_st, m_left, m_last, m_gidx, m_retry;
  bit limit_en;

  function automatic int dwell_of(int s);
    if (s == 0) return BOOT;
    if (s == 3) return RETRY;
    if (s == 5) return NAPC;
    return 0;
  endfunction

  task automatic m_go(int s);
    m_st   = s;
    m_left = dwell_of(s);
  endtask

  task automatic m_reset();
    m_go(0);
    m_last  = N - 1;
    m_gidx  = -1;
    m_retry = 0;
  endtask

  task automatic m_step();
    case (m_st)
      0: if (m_left == 1) m_go(1); else m_left--;
      1: m_go(2);
      2: if (mac_send_end) m_go(3);
      3: begin
        if (arp_found) begin
          m_retry = 0;
          m_go(4);
        end else if (m_left == 1) begin
          m_retry++;
          if (limit_en && m_retry >= MAXR) m_go(10); else m_go(1);
        end else m_left--;
      end
      4: m_go(5);
      5: if (m_left == 1) m_go(6); else m_left--;
      6: if (mac_not_exist) m_go(1); else if (!almost_full) m_go(7);
      7: begin
        if (udp_rx_dv) m_go(9);
        else if (fs_tx != 0) begin
          for (int k = 1; k <= N; k++)
            if (m_gidx < 0 && fs_tx[(m_last + k) % N]) m_gidx = (m_last + k) % N;
          m_last = m_gidx;
          m_go(8);
        end
      end
      8: if (fd_tx[m_gidx]) begin m_gidx = -1; m_go(5); end
      9: if (fd_udp_rx) m_go(5);
      default: ;
    endcase
  endtask

  always @(posedge gmii_tx_clk or posedge rst) begin
    if (rst) m_reset();
    else     m_step();
  end

  always @(negedge gmii_tx_clk) begin
    chk("state", int'(state_o), m_st);
    chk("arp_request_req", int'(arp_request_req), int'(m_st == 1));
    chk("fs_udp_rx", int'(fs_udp_rx), int'(m_st == 9));
    chk("link_up", int'(link_up), int'(m_st >= 5 && m_st <= 9));
    chk("tx_grant", int'(tx_grant), (m_gidx >= 0) ? (1 << m_gidx) : 0);
    chk("arp_fail", int'(arp_fail), int'(limit_en && m_st == 10));
  end

  task automatic tick();
    @(posedge gmii_tx_clk);
    #1;
  endtask

  task automatic clear_inputs();
    mac_send_end = 0; arp_found = 0; mac_not_exist = 0; almost_full = 0;
    udp_rx_dv = 0; fd_udp_rx = 0; fs_tx = '0; fd_tx = '0;
  endtask

  task automatic wait_state(int s, string name);
    int n = 0;
    while (int'(state_o) != s && n < 200) begin
      tick();
      n++;
    end
    chk(name, int'(state_o), s);
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    tick();
    tick();
    rst = 0;
  endtask

  task automatic send_and_wait();
    tick();
    mac_send_end = 1;
    tick();
    mac_send_end = 0;
  endtask

  task automatic boot_to_wait();
    int c = 1;
    do_reset();
    while (!arp_request_req && c < 100) begin
      tick();
      c++;
    end
    chk("boot_req_cycle", c, 21);
    chk("model_boot_state", m_st, 1);
    tick();
    chk("arp_req_width", int'(arp_request_req), 0);
    chk("arp_send_state", int'(state_o), 2);
    mac_send_end = 1; tick(); mac_send_end = 0;
    chk("arp_wait_state", int'(state_o), 3);
    arp_found = 1; tick(); arp_found = 0;
    chk("arp_nap0_state", int'(state_o), 4);
    tick();
    chk("nap_state", int'(state_o), 5);
    repeat (4) tick();
    chk("nap_last_state", int'(state_o), 5);
    tick();
    chk("check_state", int'(state_o), 6);
    tick();
    chk("wait_state", int'(state_o), 7);
    chk("wait_link_up", int'(link_up), 1);
  endtask

  logic [N-1:0] rr_exp [4];

  initial begin
    int n;
`ifdef MAC_ARP_RETRY_LIMIT_EN
    limit_en = 1;
`else
    limit_en = 0;
`endif
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
    clear_inputs();
    tick();
    chk("reset_state", int'(state_o), 0);
    chk("reset_grant", int'(tx_grant), 0);
    chk("reset_link_up", int'(link_up), 0);
    chk("reset_arp_req", int'(arp_request_req), 0);

    // ARP retry and optional failure
    do_reset();
    wait_state(1, "retry_first_req");
    send_and_wait();
    n = 0;
    while (!arp_request_req && !arp_fail && n < 100) begin tick(); n++; end
    chk("retry_gap", n, 30);
    chk("retry_req", int'(arp_request_req), 1);
    send_and_wait();
    n = 0;
    while (!arp_request_req && !arp_fail && n < 100) begin tick(); n++; end
    chk("retry_gap2", n, 30);
`ifdef MAC_ARP_RETRY_LIMIT_EN
    chk("fail_flag", int'(arp_fail), 1);
    repeat (3) tick();
    chk("fail_absorb", int'(state_o), 10);
`else
    chk("unbounded_retry", int'(arp_request_req), 1);
`endif

    // Boot and resolve, then RX priority over TX
    boot_to_wait();
    udp_rx_dv = 1; fs_tx = 3'b011;
    tick();
    udp_rx_dv = 0;
    chk("prio_state", int'(state_o), 9);
    chk("prio_fs_udp_rx", int'(fs_udp_rx), 1);
    chk("prio_no_grant", int'(tx_grant), 0);
    fd_udp_rx = 1; tick(); fd_udp_rx = 0;
    chk("recv_to_nap", int'(state_o), 5);
    wait_state(8, "prio_then_send");
    chk("prio_grant", int'(tx_grant), 1);

    // Round-robin with stray done bits
    fs_tx = 3'b111;
    fd_tx = 3'b110;
    tick();
    chk("rr_ignore_other_fd", int'(state_o), 8);
    chk("rr_grant_held", int'(tx_grant), int'(rr_exp[0]));
    fd_tx = rr_exp[0]; tick(); fd_tx = '0;
    chk("rr_grant_drop", int'(tx_grant), 0);
    for (int r = 1; r < 4; r++) begin
      wait_state(8, "rr_send");
      chk("rr_grant", int'(tx_grant), int'(rr_exp[r]));
      fd_tx = rr_exp[r]; tick(); fd_tx = '0;
    end

    // Back-pressure and destination loss
    fs_tx = '0;
    almost_full = 1;
    wait_state(6, "bp_check");
    repeat (3) tick();
    chk("bp_hold", int'(state_o), 6);
    almost_full = 0; mac_not_exist = 1;
    tick();
    mac_not_exist = 0;
    chk("loss_state", int'(state_o), 1);
    chk("loss_link_up", int'(link_up), 0);
    send_and_wait();
    arp_found = 1; tick(); arp_found = 0;
    wait_state(7, "relink_wait");

    // Asynchronous reset mid-SEND
    fs_tx = 3'b111;
    wait_state(8, "mid_send");
    chk("mid_grant", int'(tx_grant), 2);
    #2 rst = 1;
    #1;
    chk("async_state", int'(state_o), 0);
    chk("async_grant", int'(tx_grant), 0);
    chk("async_link_up", int'(link_up), 0);
    chk("async_arp_req", int'(arp_request_req | fs_udp_rx | arp_fail), 0);
    boot_to_wait();
    fs_tx = 3'b111;
    wait_state(8, "post_reset_send");
    chk("post_reset_grant", int'(tx_grant), 1);
    fd_tx = 3'b001; tick(); fd_tx = '0;

    // Random traffic against the model
    for (int i = 0; i < 6000; i++) begin
      rst           = ($urandom_range(0, 1499) == 0);
      mac_send_end  = ($urandom_range(0, 9) < 3);
      arp_found     = ($urandom_range(0, 9) < 1);
      mac_not_exist = ($urandom_range(0, 19) < 1);
      almost_full   = ($urandom_range(0, 9) < 3);
      udp_rx_dv     = ($urandom_range(0, 9) < 2);
      fd_udp_rx     = ($urandom_range(0, 9) < 3);
      for (int b = 0; b < N; b++) begin
        fs_tx[b] = ($urandom_range(0, 9) < 4);
        fd_tx[b] = ($urandom_range(0, 9) < 3);
      end
      tick();
    end
    rst = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
